serial_tx_bridge: RTL

Byte-serialising UART transmitter downstream of the interpreter communication stage. It accepts the 8-bit result bytes the processor streams out and buffers them in a small FIFO. It then transmits them as asynchronous serial frames (8N1, optional parity) to the host-side interpreter, decoupling the processor's result rate from the serial line rate.

---
 rtl/serial_pkg.sv | 20 ++
 rtl/tx_byte_fifo.sv | 65 ++++++
 rtl/serial_tx_bridge.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit bridge.
// Default baud settings target the 50 MHz FPGA clock at 115200 baud.
package serial_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam logic        TX_IDLE_LEVEL        = 1'b1;
    localparam int unsigned SYS_CLK_HZ           = 50_000_000;
    localparam int unsigned DEFAULT_BAUD         = 115_200;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = SYS_CLK_HZ / DEFAULT_BAUD;
    localparam int unsigned DEFAULT_FIFO_DEPTH   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/tx_byte_fifo.sv
// Single-clock byte FIFO with show-ahead output; full/empty are registered
// and derived from the occupancy count rather than pointer equality.
module tx_byte_fifo
    import serial_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_BITS-1:0]         din,
    output logic [DATA_BITS-1:0]         dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FIFO_DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic                 full_q;
    logic                 empty_q;
    logic                 push_ok;
    logic                 pop_ok;

    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_q;

    always_comb begin
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/serial_tx_bridge.sv
// Buffered UART transmitter: bytes queue in a FIFO and leave as 8N1 frames.
// Define TX_PARITY_EN to insert an even-parity bit after data bit 7.
module serial_tx_bridge
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         tx,
    output logic                         busy,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    tx_state_t            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q;
    logic                 overflow_q;
`ifdef TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 push;
    logic                 pop;
    logic                 load;
    logic                 baud_last;
    logic [CNT_W-1:0]     cnt_after;

    assign push      = in_valid && !fifo_full;
    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign load      = !fifo_empty &&
                       ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_last));
    assign cnt_after = fifo_count + CNT_W'(push) - CNT_W'(pop);

    tx_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Frame sequencing; a pending byte loads from IDLE or straight out of STOP.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_last ? '0 : baud_q + BAUD_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        pop      = 1'b0;
`ifdef TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                tx_d   = TX_IDLE_LEVEL;
            end
            ST_START: begin
                if (baud_last) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    bit_d = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = TX_IDLE_LEVEL;
`endif
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef TX_PARITY_EN
            ST_PARITY: begin
                if (baud_last) begin
                    state_d = ST_STOP;
                    tx_d    = TX_IDLE_LEVEL;
                end
            end
`endif
            ST_STOP: begin
                if (baud_last) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = TX_IDLE_LEVEL;
            end
        endcase

        if (load) begin
            pop      = 1'b1;
            shift_d  = fifo_dout;
            tx_d     = 1'b0;
            state_d  = ST_START;
            baud_d   = '0;
            bit_d    = '0;
`ifdef TX_PARITY_EN
            parity_d = ^fifo_dout;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= TX_IDLE_LEVEL;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= (state_d != ST_IDLE) || (cnt_after != '0);
            overflow_q <= overflow_q || (in_valid && fifo_full);
`ifdef TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign in_ready = !fifo_full;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule
